// File: rtl/mme_outer_acc.sv
// Outer-product matrix accumulator: K beats of (A column, B row) are summed into
// a DIM x DIM accumulator tile, then the tile is streamed out row-major.
module mme_outer_acc #(
  parameter int DIM    = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K_W-1:0]        cfg_k,
  input  logic                  cfg_acc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIM*DATA_W-1:0] in_a,
  input  logic [DIM*DATA_W-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int NEL   = DIM * DIM;
  localparam int IDX_W = (NEL > 1) ? $clog2(NEL) : 1;
  // Products are formed at least ACC_W wide so sign extension comes for free.
  localparam int PW    = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [K_W-1:0]     beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   acc_q [NEL];
  logic [ACC_W-1:0]   acc_d [NEL];
  logic [ACC_W-1:0]   prod  [NEL];

  logic last_beat;
  logic last_idx;

  assign last_beat = (beat_q == k_q - K_W'(1));
  assign last_idx  = (idx_q == IDX_W'(NEL - 1));

  always_comb begin
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_ext;
    a_ext = '0;
    b_ext = '0;
    p_ext = '0;
    for (int e = 0; e < NEL; e++) prod[e] = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        a_ext = PW'($signed(in_a[i*DATA_W +: DATA_W]));
        b_ext = PW'($signed(in_b[j*DATA_W +: DATA_W]));
        p_ext = a_ext * b_ext;
        prod[i*DIM+j] = p_ext[ACC_W-1:0];
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d    = cfg_k;
          beat_d = '0;
          idx_d  = '0;
          if (!cfg_acc) begin
            for (int e = 0; e < NEL; e++) acc_d[e] = '0;
          end
          state_d = (cfg_k != '0) ? ACCUM : DRAIN;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int e = 0; e < NEL; e++) acc_d[e] = acc_q[e] + prod[e];
          beat_d = beat_q + K_W'(1);
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_idx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset is asserted high on this block's rst_n net.
  // NOTE: the accumulator array is reset along with the control state, so an
  // interrupted job cannot leak partial sums into a later cfg_acc=1 job.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int e = 0; e < NEL; e++) acc_q[e] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int e = 0; e < NEL; e++) acc_q[e] <= acc_d[e];
    end
  end

  assign out_data = (state_q == DRAIN) ? acc_q[idx_q] : '0;
  assign out_last = (state_q == DRAIN) && last_idx;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_mme_outer_acc.sv
// Scoreboard bench for mme_outer_acc: the stimulus side pushes expected tile
// elements, a negedge monitor pops and compares on every output handshake.
module tb_mme_outer_acc;

  localparam int DIM    = 4;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 32;
  localparam int K_W    = 16;
  localparam int NEL    = DIM * DIM;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [K_W-1:0]        cfg_k;
  logic                  cfg_acc;
  logic                  in_valid;
  logic                  in_ready;
  logic [DIM*DATA_W-1:0] in_a;
  logic [DIM*DATA_W-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  mme_outer_acc #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          passed   = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] a_mem [DIM][16];
  logic [31:0] b_mem [16][DIM];
  logic [31:0] model_acc [DIM][DIM];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Consumer-side ready: always 1, or a coin toss each cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares at the negedge, i.e. with the values seen by the next edge.
  initial begin
    bit               stall_pending;
    logic [ACC_W-1:0] held_data;
    logic             held_last;
    exp_t             e;
    stall_pending = 1'b0;
    held_data     = '0;
    held_last     = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_pending && out_valid) begin
        check("stall_data", 64'(out_data), 64'(held_data));
        check("stall_last", 64'(out_last), 64'(held_last));
      end
      stall_pending = 1'b0;
      if (out_valid) begin
        check("drain_in_ready", 64'(in_ready), 64'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out: got %h expected no output", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_last", 64'(out_last), 64'(e.last));
          end
        end else begin
          stall_pending = 1'b1;
          held_data     = out_data;
          held_last     = out_last;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) model_acc[i][j] = '0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < DIM; i++) begin
        a_mem[i][k] = 32'($urandom_range(0, 255));
        b_mem[k][i] = 32'($urandom_range(0, 255));
      end
  endtask

  task automatic start_job(input int k, input bit acc);
    cfg_k   = K_W'(k);
    cfg_acc = acc;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (!acc) clear_model();
  endtask

  task automatic feed_beat(input int k, input bit gaps);
    bit     hs;
    longint p;
    in_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    for (int i = 0; i < DIM; i++) begin
      in_a[i*DATA_W +: DATA_W] = a_mem[i][k];
      in_b[i*DATA_W +: DATA_W] = b_mem[k][i];
    end
    in_valid = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 1000 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!hs) begin
      checks++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 1000 cycles");
    end else begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          p = longint'($signed(a_mem[i][k])) * longint'($signed(b_mem[k][j]));
          model_acc[i][j] = model_acc[i][j] + p[31:0];
        end
    end
  endtask

  task automatic push_expect(input bit hand, input logic [31:0] hv);
    exp_t e;
    for (int n = 0; n < NEL; n++) begin
      e.data = hand ? hv : model_acc[n / DIM][n % DIM];
      e.last = (n == NEL - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_job(input int d0);
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_job(input int k, input bit acc, input bit gaps, input int off,
                         input bit hand, input logic [31:0] hv);
    int d0;
    d0 = done_cnt;
    start_job(k, acc);
    for (int b = 0; b < k; b++) feed_beat(b + off, gaps);
    check("in_ready_after_k", 64'(in_ready), 64'd0);
    check("drain_latency", 64'(out_valid), 64'd1);
    push_expect(hand, hv);
    wait_job(d0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
  endtask

  initial begin
    int d0;
    rst_n    = 1'b1;
    start    = 1'b0;
    cfg_k    = '0;
    cfg_acc  = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    clear_model();
    #12 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic 4x4x4 tile with small unsigned operands.
    fill_random();
    run_job(4, 1'b0, 1'b0, 0, 1'b0, '0);

    // K=16 gap-free, then the same data with input gaps and output stalls.
    run_job(16, 1'b0, 1'b0, 0, 1'b0, '0);
    rand_ready = 1'b1;
    run_job(16, 1'b0, 1'b1, 0, 1'b0, '0);
    rand_ready = 1'b0;

    // Two chained jobs: cfg_acc=1 extends the sum over columns 4..7.
    run_job(4, 1'b0, 1'b0, 0, 1'b0, '0);
    run_job(4, 1'b1, 1'b0, 4, 1'b0, '0);

    // K=0 with clear drains zeros; a start during DRAIN must be ignored.
    d0 = done_cnt;
    rand_ready = 1'b1;
    start_job(0, 1'b0);
    check("k0_drain_entry", 64'(out_valid), 64'd1);
    push_expect(1'b1, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    cfg_k   = K_W'(5);
    cfg_acc = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_job(d0);
    rand_ready = 1'b0;
    check("k0_stays_idle", 64'(in_ready), 64'd0);

    // 0x7FFFFFFF squared = 0x3FFFFFFF_00000001; two beats wrap to 0x00000002.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DIM; i++) begin
        a_mem[i][k] = 32'h7FFF_FFFF;
        b_mem[k][i] = 32'h7FFF_FFFF;
      end
    run_job(2, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0002);

    // Reset two beats into a K=8 job, then a fresh K=8 job that keeps accumulators.
    fill_random();
    start_job(8, 1'b0);
    feed_beat(0, 1'b0);
    feed_beat(1, 1'b0);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs("midreset");
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_job(8, 1'b1, 1'b0, 0, 1'b0, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mme_outer_acc.md
MME_OUTER_ACC -- requirements
Module: mme_outer_acc

Interface
REQ-001 SHALL provide parameter DIM, default 4, the tile edge; the block computes a DIM x DIM output tile.
REQ-002 SHALL provide parameter DATA_W, default 32, the signed operand width.
REQ-003 SHALL provide parameter ACC_W, default 32, the accumulator and result width.
REQ-004 SHALL provide parameter K_W, default 16, the width of the inner-dimension length field.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle job request, honoured only in IDLE.
REQ-008 SHALL have port cfg_k  input  K_W  inner dimension K (number of input beats), sampled on start.
REQ-009 SHALL have port cfg_acc  input  1  sampled on start; 1 = keep prior accumulators, 0 = clear them.
REQ-010 SHALL have port in_valid  input  1  an input beat is present.
REQ-011 SHALL have port in_ready  output  1  the block accepts the input beat.
REQ-012 SHALL have port in_a  input  DIM*DATA_W  A column k; lane i (bits i*DATA_W+:DATA_W) = A[i][k].
REQ-013 SHALL have port in_b  input  DIM*DATA_W  B row k; lane j = B[k][j].
REQ-014 SHALL have port out_valid  output  1  a result element is present.
REQ-015 SHALL have port out_ready  input  1  the consumer accepts the result element.
REQ-016 SHALL have port out_data  output  ACC_W  result element C[r][c].
REQ-017 SHALL have port out_last  output  1  high with the final element of a tile.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse when a job completes.

Function
REQ-020 SHALL implement the states IDLE, ACCUM and DRAIN.
REQ-021 In IDLE with start=1, the block SHALL latch cfg_k and cfg_acc, clear all DIM*DIM accumulators if cfg_acc=0, and enter ACCUM if cfg_k!=0, else enter DRAIN.
REQ-022 In ACCUM, in_ready SHALL be 1; in every other state in_ready SHALL be 0.
REQ-023 On each in_valid&&in_ready cycle, the block SHALL update acc[i][j] += signed(a_i)*signed(b_j) for all i,j in that cycle, increment the beat counter, and leave the accumulators unchanged on cycles without a handshake.
REQ-024 Arithmetic SHALL use a full 2*DATA_W signed product, truncated or sign-extended to ACC_W, with the accumulation wrapping modulo 2^ACC_W.
REQ-025 The handshake that completes beat K SHALL move the block to DRAIN on the next edge; any further in_valid SHALL then see in_ready=0.
REQ-026 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal acc[r][c], with the index running row-major r*DIM+c from 0 to DIM*DIM-1; the first element SHALL appear in the cycle after DRAIN is entered (latency 1 cycle from the last input handshake).
REQ-027 The output index SHALL advance only on out_valid&&out_ready; out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-028 out_last SHALL equal 1 only for index DIM*DIM-1; its handshake SHALL return the block to IDLE, and done SHALL pulse for exactly 1 cycle on the next cycle.
REQ-029 A start received while busy=1 SHALL be ignored, and the latched configuration SHALL not change.
REQ-030 The accumulators SHALL hold their values in IDLE, so that a subsequent job with cfg_acc=1 continues from them; when cfg_k=0 the job SHALL drain the held or cleared values unchanged.
REQ-031 The beat counter SHALL be K_W bits and SHALL support the maximum K = 2^K_W-1 without wrapping before completion.

Reset
REQ-032 While rst_n is asserted, the block SHALL immediately force state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0, beat and index counters=0, and all accumulators=0, including when reset arrives mid-ACCUM or mid-DRAIN.
REQ-033 After reset release, the first start SHALL behave as in REQ-021, and no partial results from the interrupted job SHALL be emitted.

Verification
REQ-034 Bench SHALL cover: DIM=4, K=4, random unsigned 0..255 operands -> 16 outputs matching the reference A x B mod 2^32 in row-major order, out_last only on element 15, single done pulse.
REQ-035 Bench SHALL cover: K=16 with random in_valid gaps and out_ready toggling 50% -> results identical to the gap-free run, and out_data stable while stalled.
REQ-036 Bench SHALL cover: job 1 with K=4 and cfg_acc=0, then job 2 with K=4 and cfg_acc=1 -> job-2 outputs equal the sum of both products, i.e. the 4x8 x 8x4 result.
REQ-037 Bench SHALL cover: cfg_k=0, cfg_acc=0 -> 16 zero outputs, then IDLE and a done pulse; a start issued during DRAIN is ignored.
REQ-038 Bench SHALL cover: signed overflow case with A=B=0x7FFFFFFF and K=2 -> each element equals 0x00000002, showing the wrap to 32 bits.
REQ-039 Bench SHALL cover: reset asserted after 2 of 8 beats -> all outputs 0 immediately; a fresh K=8 job then yields correct results.
